// File: rtl/uart_reg_bridge_if.sv
// Byte-FIFO side of the uart block plus the single-beat register bus, as seen by the bridge.
// The bridge uses the master view; the uart/register environment uses the slave view.
interface uart_reg_bridge_if;
  logic [7:0] uart_r_data;
  logic       uart_rx_empty;
  logic       uart_rd;
  logic [7:0] uart_w_data;
  logic       uart_wr;
  logic       uart_tx_full;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;

  modport master (
    input  uart_r_data, uart_rx_empty, uart_tx_full, reg_rdata,
    output uart_rd, uart_w_data, uart_wr, reg_addr, reg_wdata, reg_we, reg_re
  );

  modport slave (
    output uart_r_data, uart_rx_empty, uart_tx_full, reg_rdata,
    input  uart_rd, uart_w_data, uart_wr, reg_addr, reg_wdata, reg_we, reg_re
  );
endinterface

// File: rtl/uart_reg_bridge.sv
// Parses 'R addr' / 'W addr data' frames from the uart rx FIFO, runs one register bus access
// per frame and pushes a single response byte (data, ACK or NAK) into the tx FIFO.
module uart_reg_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  CMD_RD         = 8'h52,
  parameter logic [7:0]  CMD_WR         = 8'h57,
  parameter logic [7:0]  ACK            = 8'h06,
  parameter logic [7:0]  NAK            = 8'h15
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_reg_bridge_if.master     bus,
  output logic                  busy,
  output logic [7:0]            nak_count
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StGetAddr, StGetData, StBusWr, StBusRd, StRdCap, StSend
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            is_wr_q, is_wr_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      resp_q, resp_d;
  logic            nak_q, nak_d;
  logic            wr_q, wr_d;
  logic            we_q, we_d;
  logic            re_q, re_d;
  logic [7:0]      nak_count_q, nak_count_d;
  logic            pop;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    resp_d  = resp_q;
    nak_d   = nak_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!bus.uart_rx_empty) begin
          pop = 1'b1;
          if (bus.uart_r_data == CMD_RD || bus.uart_r_data == CMD_WR) begin
            is_wr_d = (bus.uart_r_data == CMD_WR);
            state_d = StGetAddr;
          end else begin
            resp_d  = NAK;
            nak_d   = 1'b1;
            state_d = StSend;
          end
        end
      end
      StGetAddr, StGetData: begin
        if (!bus.uart_rx_empty) begin
          pop = 1'b1;
          if (state_q == StGetAddr) begin
            addr_d  = bus.uart_r_data;
            state_d = is_wr_q ? StGetData : StBusRd;
          end else begin
            wdata_d = bus.uart_r_data;
            state_d = StBusWr;
          end
        end else if (cnt_q == CntLast) begin
          // Stalled frame: drop it without touching the register bus.
          resp_d  = NAK;
          nak_d   = 1'b1;
          state_d = StSend;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBusWr: begin
        resp_d  = ACK;
        nak_d   = 1'b0;
        state_d = StSend;
      end
      StBusRd: state_d = StRdCap;
      StRdCap: begin
        resp_d  = bus.reg_rdata;
        nak_d   = 1'b0;
        state_d = StSend;
      end
      StSend: begin
        if (wr_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    wr_d = (state_d == StSend) && !bus.uart_tx_full;
    we_d = (state_d == StBusWr);
    re_d = (state_d == StBusRd);

    nak_count_d = nak_count_q;
    if (wr_q && nak_q && nak_count_q != 8'hFF) nak_count_d = nak_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      resp_q      <= 8'h00;
      nak_q       <= 1'b0;
      wr_q        <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      nak_count_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      resp_q      <= resp_d;
      nak_q       <= nak_d;
      wr_q        <= wr_d;
      we_q        <= we_d;
      re_q        <= re_d;
      nak_count_q <= nak_count_d;
    end
  end

  // Never pop while reset is held, so queued bytes survive for the next frame.
  assign bus.uart_rd     = pop & ~reset;
  assign bus.uart_w_data = resp_q;
  assign bus.uart_wr     = wr_q;
  assign bus.reg_addr    = addr_q;
  assign bus.reg_wdata   = wdata_q;
  assign bus.reg_we      = we_q;
  assign bus.reg_re      = re_q;
  assign busy            = (state_q != StIdle);
  assign nak_count       = nak_count_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Bench for uart_reg_bridge: models the rx/tx FIFOs and a 256-byte register file, and checks
// responses, bus strobes and latencies against a frame-level reference model.
module tb_uart_reg_bridge;
  localparam int unsigned TO = 20;
  localparam int CMD_RD = 8'h52;
  localparam int CMD_WR = 8'h57;
  localparam int ACK    = 8'h06;
  localparam int NAK    = 8'h15;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic [7:0] nak_count;

  uart_reg_bridge_if bus ();

  uart_reg_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .nak_count(nak_count)
  );

  always #5 clk = ~clk;

  int total, bad, cyc, exp_naks;
  logic [7:0] rxq[$];
  int pop_cyc[$], tx_cyc[$], tx_data[$], we_cyc[$], we_addr[$], we_data[$], re_cyc[$];
  logic [7:0] mem[256];
  logic [7:0] exp_mem[256];

  function automatic int at(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic int sat_inc(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  task automatic sync_rx();
    bus.uart_rx_empty = (rxq.size() == 0);
    if (rxq.size() != 0) bus.uart_r_data = rxq[0];
    else bus.uart_r_data = 8'h00;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rxq.push_back(b);
    sync_rx();
  endtask

  // All stimulus happens 2 time units after a rising edge.
  task automatic step(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_logs();
    pop_cyc.delete(); tx_cyc.delete(); tx_data.delete();
    we_cyc.delete(); we_addr.delete(); we_data.delete(); re_cyc.delete();
  endtask

  task automatic wait_tx(input int n, input int budget, output bit ok);
    int k = 0;
    while (tx_data.size() < n && k < budget) begin
      step(1);
      k++;
    end
    ok = (tx_data.size() >= n);
  endtask

  // FIFO and register-file environment: sample mid-cycle, apply effects just after the edge.
  initial begin
    bit rd_seen, re_seen;
    logic [7:0] re_addr;
    cyc = 0;
    forever begin
      @(negedge clk);
      rd_seen = bus.uart_rd;
      re_seen = bus.reg_re;
      re_addr = bus.reg_addr;
      if (rd_seen) pop_cyc.push_back(cyc);
      if (bus.uart_wr) begin
        tx_cyc.push_back(cyc);
        tx_data.push_back(int'(bus.uart_w_data));
      end
      if (bus.reg_we) begin
        we_cyc.push_back(cyc);
        we_addr.push_back(int'(bus.reg_addr));
        we_data.push_back(int'(bus.reg_wdata));
        mem[bus.reg_addr] = bus.reg_wdata;
      end
      if (re_seen) re_cyc.push_back(cyc);
      @(posedge clk);
      cyc++;
      #1;
      if (rd_seen && rxq.size() != 0) void'(rxq.pop_front());
      bus.reg_rdata = re_seen ? mem[re_addr] : 8'($urandom);
      sync_rx();
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    @(negedge clk);
    total++; if ({bus.uart_rd, bus.uart_wr, bus.reg_we, bus.reg_re, busy} !== 5'b0) begin
      bad++; $display("FAIL reset_strobes: got %b required 00000",
                      {bus.uart_rd, bus.uart_wr, bus.reg_we, bus.reg_re, busy});
    end
    total++; if (bus.uart_w_data !== 8'h00) begin
      bad++; $display("FAIL reset_w_data: got %h required 00", bus.uart_w_data);
    end
    total++; if ({bus.reg_addr, bus.reg_wdata} !== 16'h0000) begin
      bad++; $display("FAIL reset_addr_wdata: got %h required 0000", {bus.reg_addr, bus.reg_wdata});
    end
    total++; if (nak_count !== 8'h00) begin
      bad++; $display("FAIL reset_nak_count: got %h required 00", nak_count);
    end
    step(1);
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_write();
    bit ok;
    int p;
    clear_logs();
    push_byte(8'h57); push_byte(8'h03); push_byte(8'hA5);
    exp_mem[3] = 8'hA5;
    wait_tx(1, 30, ok);
    step(2);
    p = at(pop_cyc, 0);
    total++; if (!ok || pop_cyc.size() != 3 || at(pop_cyc, 2) != p + 2) begin
      bad++; $display("FAIL write_pops: got %0d pops, required 3 consecutive", pop_cyc.size());
    end
    total++; if (we_cyc.size() != 1 || at(we_cyc, 0) != p + 3) begin
      bad++; $display("FAIL write_we_cycle: got %0d required %0d", at(we_cyc, 0), p + 3);
    end
    total++; if (at(we_addr, 0) != 8'h03 || at(we_data, 0) != 8'hA5) begin
      bad++; $display("FAIL write_bus: got addr %0h data %0h required 3 a5",
                      at(we_addr, 0), at(we_data, 0));
    end
    total++; if (at(tx_cyc, 0) != p + 4 || at(tx_data, 0) != ACK) begin
      bad++; $display("FAIL write_ack: got %0h at %0d required 06 at %0d",
                      at(tx_data, 0), at(tx_cyc, 0), p + 4);
    end
  endtask

  task automatic test_read();
    bit ok;
    int pa;
    clear_logs();
    push_byte(8'h52); push_byte(8'h03);
    wait_tx(1, 30, ok);
    step(2);
    pa = at(pop_cyc, 1);
    total++; if (!ok || re_cyc.size() != 1 || at(re_cyc, 0) != pa + 1 || we_cyc.size() != 0) begin
      bad++; $display("FAIL read_re: got re at %0d (%0d we), required %0d",
                      at(re_cyc, 0), we_cyc.size(), pa + 1);
    end
    total++; if (at(tx_cyc, 0) != pa + 3 || at(tx_data, 0) != int'(exp_mem[3])) begin
      bad++; $display("FAIL read_resp: got %0h at %0d required %0h at %0d",
                      at(tx_data, 0), at(tx_cyc, 0), exp_mem[3], pa + 3);
    end
  endtask

  task automatic test_bad_opcode();
    bit ok;
    clear_logs();
    push_byte(8'h41);
    exp_naks = sat_inc(exp_naks);
    wait_tx(1, 20, ok);
    step(2);
    total++; if (!ok || at(tx_data, 0) != NAK || at(tx_cyc, 0) != at(pop_cyc, 0) + 1) begin
      bad++; $display("FAIL bad_nak: got %0h at %0d required 15 at %0d",
                      at(tx_data, 0), at(tx_cyc, 0), at(pop_cyc, 0) + 1);
    end
    total++; if (we_cyc.size() + re_cyc.size() != 0) begin
      bad++; $display("FAIL bad_no_bus: got %0d strobes required 0", we_cyc.size() + re_cyc.size());
    end
    total++; if (int'(nak_count) != exp_naks) begin
      bad++; $display("FAIL bad_nak_count: got %0d required %0d", nak_count, exp_naks);
    end
    clear_logs();
    push_byte(8'h52); push_byte(8'h00);
    wait_tx(1, 30, ok);
    total++; if (at(tx_data, 0) != int'(exp_mem[0])) begin
      bad++; $display("FAIL bad_then_read: got %0h required %0h", at(tx_data, 0), exp_mem[0]);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int last;
    clear_logs();
    push_byte(8'h57); push_byte(8'h10);
    exp_naks = sat_inc(exp_naks);
    wait_tx(1, 80, ok);
    step(2);
    last = at(pop_cyc, 1);
    total++; if (!ok || at(tx_cyc, 0) != last + TO + 1 || at(tx_data, 0) != NAK) begin
      bad++; $display("FAIL timeout_nak: got %0h at %0d required 15 at %0d",
                      at(tx_data, 0), at(tx_cyc, 0), last + TO + 1);
    end
    total++; if (we_cyc.size() != 0) begin
      bad++; $display("FAIL timeout_no_we: got %0d required 0", we_cyc.size());
    end
    clear_logs();
    push_byte(8'hA5);
    exp_naks = sat_inc(exp_naks);
    wait_tx(1, 20, ok);
    step(2);
    total++; if (!ok || at(tx_data, 0) != NAK || at(tx_cyc, 0) != at(pop_cyc, 0) + 1) begin
      bad++; $display("FAIL late_byte_opcode: got %0h required 15", at(tx_data, 0));
    end
    total++; if (int'(nak_count) != exp_naks) begin
      bad++; $display("FAIL timeout_nak_count: got %0d required %0d", nak_count, exp_naks);
    end
  endtask

  task automatic test_tx_full();
    bit ok;
    int rel;
    clear_logs();
    bus.uart_tx_full = 1'b1;
    push_byte(8'h41); push_byte(8'h52); push_byte(8'h07);
    exp_naks = sat_inc(exp_naks);
    step(50);
    @(negedge clk);
    total++; if (tx_data.size() != 0 || pop_cyc.size() != 1 || busy !== 1'b1) begin
      bad++; $display("FAIL txfull_hold: got %0d wr %0d pops busy %b required 0 1 1",
                      tx_data.size(), pop_cyc.size(), busy);
    end
    step(1);
    rel = cyc;
    bus.uart_tx_full = 1'b0;
    wait_tx(2, 40, ok);
    step(3);
    total++; if (at(tx_cyc, 0) != rel + 1 || at(tx_data, 0) != NAK) begin
      bad++; $display("FAIL txfull_release: got %0h at %0d required 15 at %0d",
                      at(tx_data, 0), at(tx_cyc, 0), rel + 1);
    end
    total++; if (!ok || tx_data.size() != 2 || at(tx_data, 1) != int'(exp_mem[7])) begin
      bad++; $display("FAIL txfull_next_frame: got %0d bytes last %0h required 2 bytes last %0h",
                      tx_data.size(), at(tx_data, 1), exp_mem[7]);
    end
  endtask

  task automatic test_random();
    int exp_tx[$], exp_wa[$], exp_wd[$];
    int nbytes, kind;
    bit ok;
    logic [7:0] op, a, d;
    clear_logs();
    nbytes = 0;
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 7);
      a = 8'($urandom);
      d = 8'($urandom);
      if (kind == 0) begin
        do op = 8'($urandom); while (op == 8'(CMD_RD) || op == 8'(CMD_WR));
        push_byte(op);
        nbytes += 1;
        exp_tx.push_back(NAK);
        exp_naks = sat_inc(exp_naks);
      end else if (kind < 4) begin
        push_byte(8'(CMD_RD)); step($urandom_range(0, 3)); push_byte(a);
        nbytes += 2;
        exp_tx.push_back(int'(exp_mem[a]));
      end else begin
        push_byte(8'(CMD_WR)); step($urandom_range(0, 3)); push_byte(a);
        step($urandom_range(0, 3)); push_byte(d);
        nbytes += 3;
        exp_mem[a] = d;
        exp_wa.push_back(int'(a)); exp_wd.push_back(int'(d));
        exp_tx.push_back(ACK);
      end
      step($urandom_range(0, 3));
    end
    wait_tx(exp_tx.size(), 3000, ok);
    step(3);
    total++; if (!ok || tx_data.size() != exp_tx.size() || pop_cyc.size() != nbytes) begin
      bad++; $display("FAIL rand_counts: got %0d tx %0d pops required %0d tx %0d pops",
                      tx_data.size(), pop_cyc.size(), exp_tx.size(), nbytes);
    end
    for (int i = 0; i < exp_tx.size(); i++) begin
      total++; if (at(tx_data, i) != exp_tx[i]) begin
        bad++; $display("FAIL rand_tx[%0d]: got %0h required %0h", i, at(tx_data, i), exp_tx[i]);
      end
    end
    total++; if (we_addr.size() != exp_wa.size()) begin
      bad++; $display("FAIL rand_we_count: got %0d required %0d", we_addr.size(), exp_wa.size());
    end
    for (int i = 0; i < exp_wa.size(); i++) begin
      total++; if (at(we_addr, i) != exp_wa[i] || at(we_data, i) != exp_wd[i]) begin
        bad++; $display("FAIL rand_we[%0d]: got %0h/%0h required %0h/%0h", i,
                        at(we_addr, i), at(we_data, i), exp_wa[i], exp_wd[i]);
      end
    end
    total++; if (int'(nak_count) != exp_naks) begin
      bad++; $display("FAIL rand_nak_count: got %0d required %0d", nak_count, exp_naks);
    end
  endtask

  task automatic test_reset_mid_and_saturate();
    bit ok;
    int nonnak;
    logic [7:0] op;
    clear_logs();
    push_byte(8'h57); push_byte(8'h20);
    step(4);
    @(negedge clk);
    total++; if (busy !== 1'b1 || pop_cyc.size() != 2) begin
      bad++; $display("FAIL mid_in_get_data: got busy %b pops %0d required 1 2", busy, pop_cyc.size());
    end
    step(1);
    reset = 1'b1;
    push_byte(8'h33);
    step(1);
    @(negedge clk);
    total++; if ({bus.uart_rd, bus.uart_wr, bus.reg_we, bus.reg_re, busy} !== 5'b0) begin
      bad++; $display("FAIL mid_reset_strobes: got %b required 00000",
                      {bus.uart_rd, bus.uart_wr, bus.reg_we, bus.reg_re, busy});
    end
    total++; if ({bus.uart_w_data, bus.reg_addr, bus.reg_wdata, nak_count} !== 32'h0) begin
      bad++; $display("FAIL mid_reset_values: got %h required 00000000",
                      {bus.uart_w_data, bus.reg_addr, bus.reg_wdata, nak_count});
    end
    step(1);
    reset = 1'b0;
    exp_naks = 1;
    wait_tx(1, 20, ok);
    step(2);
    total++; if (!ok || tx_data.size() != 1 || at(tx_data, 0) != NAK || we_cyc.size() != 0) begin
      bad++; $display("FAIL mid_stale_byte: got %0d tx first %0h %0d we required 1 tx 15 0 we",
                      tx_data.size(), at(tx_data, 0), we_cyc.size());
    end
    for (int i = 0; i < 255; i++) begin
      do op = 8'($urandom); while (op == 8'(CMD_RD) || op == 8'(CMD_WR));
      push_byte(op);
      exp_naks = sat_inc(exp_naks);
    end
    wait_tx(256, 2000, ok);
    step(3);
    nonnak = 0;
    foreach (tx_data[i]) if (tx_data[i] != NAK) nonnak++;
    total++; if (!ok || tx_data.size() != 256 || nonnak != 0) begin
      bad++; $display("FAIL sat_responses: got %0d tx %0d non-NAK required 256 0",
                      tx_data.size(), nonnak);
    end
    total++; if (int'(nak_count) != exp_naks) begin
      bad++; $display("FAIL sat_nak_count: got %0d required %0d", nak_count, exp_naks);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    exp_naks = 0;
    reset = 1'b1;
    bus.uart_tx_full = 1'b0;
    bus.reg_rdata = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      exp_mem[i] = mem[i];
    end
    sync_rx();
    test_reset();
    test_write();
    test_read();
    test_bad_opcode();
    test_timeout();
    test_tx_full();
    test_random();
    test_reset_mid_and_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
